key_debounce_scan: RTL and testbench

KEY_DEBOUNCE_SCAN -- requirements
Module: key_debounce_scan

---
 rtl/key_debounce_scan.sv | 192 +++++++++++++++++++
 tb/tb_key_debounce_scan.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_scan.sv
// Four-key debouncer: two-flop synchronizers, a shared sample tick and one FSM per key
// that produces a debounced level, press/release/long-press pulses and a lowest-key code.
module key_debounce_scan #(
    parameter int unsigned TICK_DIV    = 240000,
    parameter int unsigned DEB_SAMPLES = 3,
    parameter int unsigned HOLD_TICKS  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic [2:0] key_code
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES + 1) : 1;
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] DEB_LIM   = SW'(DEB_SAMPLES);
    localparam logic [SW-1:0] SMP_ONE   = SW'(1);
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_TICKS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } state_e;

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tick;

    logic [3:0]    sync1_q, sync2_q;

    state_e        state_q [4];
    state_e        state_d [4];
    logic [SW-1:0] smp_q   [4];
    logic [SW-1:0] smp_d   [4];
    logic [HW-1:0] hold_q  [4];
    logic [HW-1:0] hold_d  [4];

    logic [3:0]    press_q, press_d;
    logic [3:0]    release_q, release_d;
    logic [3:0]    long_q, long_d;
    logic [2:0]    code_q, code_d;

    always_comb begin
        tick   = (tcnt_q == TICK_LAST);
        tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt_q  <= '0;
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            tcnt_q  <= tcnt_d;
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // With DEB_SAMPLES = 1 the first qualifying sample already equals the limit,
    // so IDLE/PRESSED jump straight across the CHK state within one tick.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            state_d[k]   = state_q[k];
            smp_d[k]     = smp_q[k];
            hold_d[k]    = hold_q[k];
            press_d[k]   = 1'b0;
            release_d[k] = 1'b0;
            long_d[k]    = 1'b0;
            if (tick) begin
                case (state_q[k])
                    IDLE: begin
                        if (!sync2_q[k]) begin
                            if (SMP_ONE == DEB_LIM) begin
                                state_d[k] = PRESSED;
                                smp_d[k]   = '0;
                                hold_d[k]  = '0;
                                press_d[k] = 1'b1;
                            end else begin
                                state_d[k] = PRESS_CHK;
                                smp_d[k]   = SMP_ONE;
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (!sync2_q[k]) begin
                            if (smp_q[k] + SMP_ONE == DEB_LIM) begin
                                state_d[k] = PRESSED;
                                smp_d[k]   = '0;
                                hold_d[k]  = '0;
                                press_d[k] = 1'b1;
                            end else begin
                                smp_d[k] = smp_q[k] + SMP_ONE;
                            end
                        end else begin
                            state_d[k] = IDLE;
                            smp_d[k]   = '0;
                        end
                    end
                    PRESSED: begin
                        if (!sync2_q[k]) begin
                            if (hold_q[k] < HOLD_LIM) begin
                                hold_d[k] = hold_q[k] + 1'b1;
                                long_d[k] = (hold_q[k] + 1'b1 == HOLD_LIM);
                            end
                        end else if (SMP_ONE == DEB_LIM) begin
                            state_d[k]   = IDLE;
                            smp_d[k]     = '0;
                            release_d[k] = 1'b1;
                        end else begin
                            state_d[k] = REL_CHK;
                            smp_d[k]   = SMP_ONE;
                        end
                    end
                    REL_CHK: begin
                        if (sync2_q[k]) begin
                            if (smp_q[k] + SMP_ONE == DEB_LIM) begin
                                state_d[k]   = IDLE;
                                smp_d[k]     = '0;
                                release_d[k] = 1'b1;
                            end else begin
                                smp_d[k] = smp_q[k] + SMP_ONE;
                            end
                        end else begin
                            // Bounce during release: hold count kept so key_long cannot re-fire.
                            state_d[k] = PRESSED;
                            smp_d[k]   = '0;
                        end
                    end
                    default: begin
                        state_d[k] = IDLE;
                        smp_d[k]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < 4; k++) begin
                state_q[k] <= IDLE;
                smp_q[k]   <= '0;
                hold_q[k]  <= '0;
            end
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            code_q    <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                smp_q[k]   <= smp_d[k];
                hold_q[k]  <= hold_d[k];
            end
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            key_state[k] = (state_q[k] == PRESSED) || (state_q[k] == REL_CHK);
        end
    end

    // Scan from the top down so the lowest-numbered pressed key wins.
    always_comb begin
        code_d = '0;
        for (int unsigned k = 4; k > 0; k--) begin
            if (key_state[k-1]) begin
                code_d = 3'(k);
            end
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_code    = code_q;

endmodule

// File: tb/tb_key_debounce_scan.sv
// Bench for key_debounce_scan: run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_key_debounce_scan;

    localparam int TD = 4;
    localparam int DS = 3;
    localparam int HT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_state, key_press, key_release, key_long;
    logic [2:0] key_code;

    key_debounce_scan #(
        .TICK_DIV   (TD),
        .DEB_SAMPLES(DS),
        .HOLD_TICKS (HT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .key_code   (key_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [2:0] code_of(input logic [3:0] s);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 3; i >= 0; i--) if (s[i]) c = 3'(i + 1);
        return c;
    endfunction

    // Model: accepted level flips after DS consecutive samples opposite to it.
    int         m_edge;
    logic [3:0] m_s1, m_s2;
    logic [3:0] m_lvl;
    int         m_run  [4];
    int         m_hold [4];
    logic [3:0] e_state, e_press, e_rel, e_long;
    logic [2:0] e_code;

    int gcyc = 0;
    int press_cnt [4], rel_cnt [4], long_cnt [4], press_at [4], long_at [4];

    initial begin
        for (int k = 0; k < 4; k++) begin
            press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
            press_at[k]  = 0; long_at[k] = 0;
        end
    end

    always @(negedge clk) begin
        gcyc++;
        if (!rst) begin
            m_edge = 0; m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'h0;
            for (int k = 0; k < 4; k++) begin m_run[k] = 0; m_hold[k] = 0; end
            e_state = '0; e_press = '0; e_rel = '0; e_long = '0; e_code = '0;
        end else begin
            e_code  = code_of(e_state);
            e_press = '0; e_rel = '0; e_long = '0;
            m_edge++;
            if (m_edge % TD == 0) begin
                for (int k = 0; k < 4; k++) begin
                    if (!m_lvl[k]) begin
                        if (!m_s2[k]) begin
                            m_run[k]++;
                            if (m_run[k] == DS) begin
                                m_lvl[k] = 1'b1; m_run[k] = 0; m_hold[k] = 0; e_press[k] = 1'b1;
                            end
                        end else m_run[k] = 0;
                    end else begin
                        if (m_s2[k]) begin
                            m_run[k]++;
                            if (m_run[k] == DS) begin
                                m_lvl[k] = 1'b0; m_run[k] = 0; e_rel[k] = 1'b1;
                            end
                        end else if (m_run[k] == 0) begin
                            if (m_hold[k] < HT) begin
                                m_hold[k]++;
                                if (m_hold[k] == HT) e_long[k] = 1'b1;
                            end
                        end else m_run[k] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
            e_state = m_lvl;
        end

        check("key_state",   key_state,   e_state);
        check("key_press",   key_press,   e_press);
        check("key_release", key_release, e_rel);
        check("key_long",    key_long,    e_long);
        check("key_code",    key_code,    e_code);
        check("tick",        dut.tick,    (m_edge % TD == TD - 1));

        for (int k = 0; k < 4; k++) begin
            if (key_press[k])   begin press_cnt[k]++; press_at[k] = gcyc; end
            if (key_release[k]) rel_cnt[k]++;
            if (key_long[k])    begin long_cnt[k]++; long_at[k] = gcyc; end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * TD) step();
    endtask

    task automatic align();
        step();
        while (m_edge % TD != 0) step();
    endtask

    task automatic wait_press(input int k, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!key_press[k] && lat < 40);
    endtask

    int lat;

    initial begin
        rst = 1'b0;
        key_n = 4'hF;
        repeat (5) step();
        check("reset_state", key_state, 4'b0000);
        check("reset_code",  key_code,  3'd0);
        rst = 1'b1;

        // Idle 100 clk: nothing may happen
        repeat (100) step();
        check("idle_pulses", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]
                             + rel_cnt[0] + long_cnt[0], 0);
        check("idle_state", key_state, 4'b0000);

        // Key 0 press: third low sample tick lands 12 clk after the drive
        align();
        key_n[0] = 1'b0;
        wait_press(0, lat);
        check("k0_press_latency", lat, 12);
        check("k0_state_at_press", key_state, 4'b0001);
        check("k0_code_lags", key_code, 3'd0);
        step();
        check("k0_press_width", key_press[0], 1'b0);
        check("k0_code", key_code, 3'd1);

        // Key 2 glitch: two low samples only
        align();
        key_n[2] = 1'b0;
        wait_ticks(2);
        key_n[2] = 1'b1;
        wait_ticks(4);
        check("k2_glitch_press", press_cnt[2], 0);
        check("k2_glitch_state", key_state[2], 1'b0);

        // Key 1 long press
        align();
        key_n[1] = 1'b0;
        wait_press(1, lat);
        check("k1_press_latency", lat, 12);
        wait_ticks(12);
        check("k1_press_once", press_cnt[1], 1);
        check("k1_long_once", long_cnt[1], 1);
        check("k1_long_delay", long_at[1] - press_at[1], 5 * TD);
        check("k0_long_once", long_cnt[0], 1);

        // Release keys 0 and 1
        align();
        key_n = 4'hF;
        wait_ticks(5);
        check("k0_release", rel_cnt[0], 1);
        check("k1_release", rel_cnt[1], 1);
        check("all_released", key_state, 4'b0000);

        // Keys 3 and 1 together
        align();
        key_n = 4'b0101;
        wait_ticks(5);
        check("k31_state", key_state, 4'b1010);
        check("k31_code", key_code, 3'd2);
        check("k31_same_clk", press_at[1] - press_at[3], 0);

        // Key 1 bounces up for two ticks: no release
        align();
        key_n[1] = 1'b1;
        wait_ticks(2);
        key_n[1] = 1'b0;
        wait_ticks(5);
        check("k1_bounce_release", rel_cnt[1], 1);
        check("k1_bounce_state", key_state, 4'b1010);
        check("k1_bounce_press", press_cnt[1], 2);

        // Reset while key 0 is pressed
        align();
        key_n = 4'b1110;
        wait_ticks(6);
        check("k0_repress_state", key_state, 4'b0001);
        check("k0_repress_count", press_cnt[0], 2);
        rst = 1'b0;
        repeat (10) step();
        check("rst_mid_state", key_state, 4'b0000);
        check("rst_mid_code", key_code, 3'd0);
        check("rst_mid_release", rel_cnt[0], 1);
        rst = 1'b1;
        wait_press(0, lat);
        check("k0_post_reset_latency", lat, 12);
        check("k0_post_reset_release", rel_cnt[0], 1);
        check("k0_post_reset_press", press_cnt[0], 3);
        wait_ticks(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
